// File: rtl/eth_64b66b_pkg.sv
// eth_64b66b_pkg: shared 64b/66b types, sync headers and lock states.
// Used by block_lock_66b and neighbouring PCS stages.
package eth_64b66b_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef logic [65:0] block_t;

  typedef enum logic [1:0] {
    HUNT,
    SLIP_WAIT,
    LOCKED
  } lock_state_t;

  function automatic logic sh_valid(input logic [1:0] sh);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (sh == SH_DATA): ok = 1'b1;
      (sh == SH_CTRL): ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/block_lock_66b.sv
// block_lock_66b: 66b sync-header block lock with bitslip request.
// Define BLOCK_LOCK_STATS_EN for sh_err_cnt / slip_cnt outputs.
module block_lock_66b
  import eth_64b66b_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  block_t      s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output block_t      m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        slip,
  output logic        block_lock
`ifdef BLOCK_LOCK_STATS_EN
  ,
  output logic [31:0] sh_err_cnt,
  output logic [31:0] slip_cnt
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

  // The parameter SLIP_WAIT hides the enum literal of the same name.
  localparam lock_state_t ST_WAIT = eth_64b66b_pkg::SLIP_WAIT;

  lock_state_t   state;
  logic [GW-1:0] good_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic [SW-1:0] wait_cnt;
  logic          acc;
  logic          hdr_ok;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign hdr_ok        = sh_valid(s_axis_tdata[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      good_cnt      <= '0;
      win_cnt       <= '0;
      err_cnt       <= '0;
      wait_cnt      <= '0;
      slip          <= 1'b0;
      block_lock    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
    end else begin
      slip <= 1'b0;
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (acc) begin
        unique case (state)
          HUNT: begin
            if (!hdr_ok) begin
              good_cnt <= '0;
              slip     <= 1'b1;
              state    <= ST_WAIT;
            end else if (good_cnt == GOOD_LAST) begin
              good_cnt   <= '0;
              win_cnt    <= '0;
              err_cnt    <= '0;
              block_lock <= 1'b1;
              state      <= LOCKED;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
          ST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt <= '0;
              good_cnt <= '0;
              state    <= HUNT;
            end else begin
              wait_cnt <= wait_cnt + SW'(1);
            end
          end
          LOCKED: begin
            // Error limit takes priority over window end.
            if (!hdr_ok && err_cnt == ERR_LAST) begin
              win_cnt    <= '0;
              err_cnt    <= '0;
              block_lock <= 1'b0;
              slip       <= 1'b1;
              state      <= ST_WAIT;
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tuser  <= ~hdr_ok;
              if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                err_cnt <= '0;
              end else begin
                win_cnt <= win_cnt + WW'(1);
                if (!hdr_ok) err_cnt <= err_cnt + EW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef BLOCK_LOCK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_err_cnt <= '0;
      slip_cnt   <= '0;
    end else begin
      if (acc && !hdr_ok && state != ST_WAIT && sh_err_cnt != '1)
        sh_err_cnt <= sh_err_cnt + 32'd1;
      if (slip && slip_cnt != '1)
        slip_cnt <= slip_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_lock_66b.sv
// tb_block_lock_66b: directed bench for block_lock_66b.
// Covers lock, hunt slip, error window, loss of lock, backpressure, reset.
module tb_block_lock_66b;
  import eth_64b66b_pkg::*;

  logic   clk = 1'b0;
  logic   reset_n;
  block_t s_axis_tdata;
  logic   s_axis_tvalid;
  logic   s_axis_tready;
  block_t m_axis_tdata;
  logic   m_axis_tuser;
  logic   m_axis_tvalid;
  logic   m_axis_tready;
  logic   slip;
  logic   block_lock;
`ifdef BLOCK_LOCK_STATS_EN
  logic [31:0] sh_err_cnt;
  logic [31:0] slip_cnt;
`endif

  int errors = 0;
  int checks = 0;

  int     fwd_cnt;
  int     tuser_cnt;
  int     slip_seen;
  int     slip_dbl;
  logic   slip_q;
  block_t last_fwd;

  logic [63:0] idx;
  logic [63:0] k;
  int          f0;

  always #5 clk = ~clk;

  block_lock_66b dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .slip          (slip),
    .block_lock    (block_lock)
`ifdef BLOCK_LOCK_STATS_EN
    ,
    .sh_err_cnt    (sh_err_cnt),
    .slip_cnt      (slip_cnt)
`endif
  );

  // Output observer; inputs change 1 time unit after posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      fwd_cnt   = 0;
      tuser_cnt = 0;
      slip_seen = 0;
      slip_dbl  = 0;
      slip_q    = 1'b0;
      last_fwd  = '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        fwd_cnt++;
        if (m_axis_tuser) tuser_cnt++;
        last_fwd = m_axis_tdata;
      end
      if (slip) slip_seen++;
      if (slip && slip_q) slip_dbl++;
      slip_q = slip;
    end
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs,
                      input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input block_t obs,
                      input block_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] sh);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {idx, sh};
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    idx           = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_m_tuser", m_axis_tuser, 1'b0);
    chkd("rst_m_tdata", m_axis_tdata, '0);
    chk1("rst_slip", slip, 1'b0);
    chk1("rst_block_lock", block_lock, 1'b0);
    reset_n = 1'b1;

    // Initial lock: 64 good headers, 65th is first forwarded
    repeat (63) send(SH_DATA);
    chk1("A_no_lock_at_63", block_lock, 1'b0);
    send(SH_DATA);
    chk1("A_lock_at_64", block_lock, 1'b1);
    chk1("A_64th_not_fwd", m_axis_tvalid, 1'b0);
    send(SH_DATA);
    chk1("A_65th_valid", m_axis_tvalid, 1'b1);
    chkd("A_65th_data", m_axis_tdata, {64'd64, SH_DATA});
    idle(2);
    chki("A_fwd_cnt", fwd_cnt, 1);
    chki("A_no_slip", slip_seen, 0);

    // Hunt failure: slip, 4 discards with ignored headers, relock
    do_reset();
    repeat (10) send(SH_DATA);
    send(2'b11);
    chk1("B_slip_pulse", slip, 1'b1);
    chk1("B_lock_low", block_lock, 1'b0);
    send(2'b11);
    chk1("B_slip_one_cycle", slip, 1'b0);
    repeat (3) send(2'b00);
    repeat (63) send(SH_DATA);
    chk1("B_no_early_lock", block_lock, 1'b0);
    send(SH_DATA);
    chk1("B_relock", block_lock, 1'b1);
    idle(2);
    chki("B_one_slip", slip_seen, 1);
    chki("B_no_fwd", fwd_cnt, 0);

    // Error window: 15 bad headers in 64 blocks keeps lock
    for (int i = 0; i < 64; i++)
      send((i % 4 == 0 && i < 60) ? 2'b11 :
           ((i % 2 == 1) ? SH_CTRL : SH_DATA));
    chk1("C_lock_held", block_lock, 1'b1);
    idle(2);
    chki("C_fwd_cnt", fwd_cnt, 64);
    chki("C_tuser_cnt", tuser_cnt, 15);
    chki("C_no_new_slip", slip_seen, 1);
    repeat (15) send(2'b00);
    chk1("C_window_cleared", block_lock, 1'b1);

    // Loss of lock on 16th bad header in the window
    send(2'b00);
    chk1("D_lock_lost", block_lock, 1'b0);
    chk1("D_slip_pulse", slip, 1'b1);
    chk1("D_16th_dropped", m_axis_tvalid, 1'b0);
    send(SH_DATA);
    chk1("D_slip_one_cycle", slip, 1'b0);
    idle(2);
    chki("D_fwd_cnt", fwd_cnt, 79);
    chki("D_tuser_cnt", tuser_cnt, 30);
    chki("D_slip_cnt", slip_seen, 2);
    repeat (3) send(SH_DATA);
    repeat (63) send(SH_DATA);
    chk1("D_no_early_lock", block_lock, 1'b0);
    send(SH_DATA);
    chk1("D_relock", block_lock, 1'b1);
    idle(2);

    // Backpressure: output stalled 5 cycles with input pending
    f0 = fwd_cnt;
    k  = idx;
    send(SH_DATA);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {idx, SH_CTRL};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk1("E_s_tready_low", s_axis_tready, 1'b0);
      chk1("E_m_tvalid_held", m_axis_tvalid, 1'b1);
      chkd("E_m_tdata_stable", m_axis_tdata, {k, SH_DATA});
    end
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    idx++;
    chkd("E_next_data", m_axis_tdata, {k + 64'd1, SH_CTRL});
    idle(2);
    chki("E_fwd_delta", fwd_cnt - f0, 2);
    chkd("E_last_fwd", last_fwd, {k + 64'd1, SH_CTRL});
    chki("E_no_double_slip", slip_dbl, 0);

`ifdef BLOCK_LOCK_STATS_EN
    // Two loss-of-lock events
    do_reset();
    repeat (64) send(SH_DATA);
    repeat (16) send(2'b00);
    repeat (4) send(SH_DATA);
    repeat (64) send(SH_DATA);
    repeat (16) send(2'b00);
    idle(2);
    chki("F_sh_err_cnt", sh_err_cnt, 32);
    chki("F_slip_cnt", slip_cnt, 2);
`endif

    // Relock if needed, get a block in flight, then async reset
    repeat (4) send(SH_DATA);
    repeat (64) send(SH_DATA);
    send(SH_DATA);
    chk1("G_pre_rst_valid", m_axis_tvalid, 1'b1);
    chk1("G_pre_rst_lock", block_lock, 1'b1);
    s_axis_tvalid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk1("G_async_m_tvalid", m_axis_tvalid, 1'b0);
    chk1("G_async_lock", block_lock, 1'b0);
    chkd("G_async_m_tdata", m_axis_tdata, '0);
    chk1("G_async_m_tuser", m_axis_tuser, 1'b0);
    chk1("G_async_slip", slip, 1'b0);
`ifdef BLOCK_LOCK_STATS_EN
    chki("G_async_sh_err", sh_err_cnt, 0);
    chki("G_async_slip_cnt", slip_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
